op_sequencer: RTL and testbench
===============================

OP_SEQUENCER -- requirements
Module: op_sequencer

Interface
REQ-001 Parameter: TIMEOUT, default 255, max cycles spent in WAIT before abort.
REQ-002 Reset: reset, synchronous, active-high.
REQ-003 clk  in  1  rising-edge clock for all state.
REQ-004 reset  in  1  synchronous active-high reset.
REQ-005 cmd_valid/cmd_ready  in/out  1/1  command handshake, accepted when both high on a clk edge.
REQ-006 cmd_unit  in  3  000 fpu, 001 int_calc, 010 bit_manip, 011 int_log, 100 fetch, 101 store, 11x illegal.
REQ-007 cmd_op  in  3  operation code forwarded to the unit; for fetch/store, cmd_op[1:0] is the register index.
REQ-008 cmd_size  in  2  00 16-bit, 01 32-bit, 10 64-bit, 11 illegal.
REQ-009 word_valid/word_ready  in/out  1/1  operand word handshake, transfer when both high.
REQ-010 word_data  in  16  operand word, least-significant word first.
REQ-011 unit_start  out  4  one-hot single-cycle start, bit index = cmd_unit[1:0].
REQ-012 unit_op  out  3  latched cmd_op, stable from ISSUE until return to IDLE.
REQ-013 opa, opb  out  64/64  assembled operands, stable from ISSUE until return to IDLE.
REQ-014 unit_done  in  4  per-unit completion pulse.
REQ-015 unit_result  in  64  result of the selected unit, valid in the unit_done cycle.
REQ-016 res_valid  out  1  single-cycle result strobe.
REQ-017 res_data  out  64  result, held until the next res_valid.
REQ-018 res_sign  out  1  equals res_data[63].
REQ-019 res_error  out  1  qualifies res_valid: illegal command or timeout.
REQ-020 busy  out  1  high in every state except IDLE.

Function
REQ-021 States are IDLE, LOAD_A, LOAD_B, ISSUE, WAIT and DONE.
REQ-022 cmd_ready is high only in IDLE; word_ready is high only in LOAD_A/LOAD_B.
REQ-023 Word count N = 1/2/4 for size 00/01/10; word k lands in bits [16k+15:16k]; operand bits above 16N are zero.
REQ-024 On accept, opa/opb clear to 0 and the word counter clears.
REQ-025 On accept, an illegal cmd_unit or cmd_size goes to DONE with res_error=1 and res_data=0.
REQ-026 On accept, fetch goes to DONE with res_data = reg[cmd_op[1:0]] and no operand loading.
REQ-027 Otherwise the accepted command goes to LOAD_A.
REQ-028 LOAD_A: after N words go to LOAD_B, except unary commands (store, int_calc op 100, int_log op 110), which go to ISSUE; store goes to DONE instead.
REQ-029 Store: reg[idx] <= opa in the LOAD_A exit cycle; res_data = opa.
REQ-030 LOAD_B: after N words, go to ISSUE.
REQ-031 ISSUE lasts exactly 1 cycle: unit_start bit asserted, timeout counter cleared, next state WAIT.
REQ-032 WAIT: when unit_done[sel] is high, capture unit_result into res_data and go to DONE.
REQ-033 WAIT: unit_done bits of non-selected units are ignored.
REQ-034 WAIT: when the counter reaches TIMEOUT without done, go to DONE with res_error=1 and res_data=0.
REQ-035 Done on the same cycle as the counter reaching TIMEOUT takes priority over timeout.
REQ-036 DONE lasts 1 cycle with res_valid=1, then IDLE; minimum accept-to-res_valid latency is 1 cycle for fetch/illegal commands.
REQ-037 Register file: 4x64, readable only via fetch; store is its only write path.
REQ-038 Idle word_valid is ignored; words are not buffered.

Reset
REQ-039 On reset (any state, including mid-load or WAIT): state=IDLE; opa, opb, res_data, reg[0..3] and counters = 0; unit_start, res_valid, res_error and busy = 0; unit_op = 0.
REQ-040 Reset takes priority over all handshakes in the same cycle; a pending unit_done after reset is ignored.

Verification
REQ-041 Reset, store unit=101 op=010 size=01, words 0x1234 then 0xABCD -> res_valid with res_data=0x00000000ABCD1234; a following fetch op=010 returns the same value one cycle after accept.
REQ-042 Unit=001 op=000 size=00, words A=0x0005, B=0x0003, done with result 8 three cycles after start -> opa=5, opb=3, unit_start=4'b0010 for one cycle, res_data=8, res_error=0.
REQ-043 Unit=011 op=110 size=10, 4 words -> no LOAD_B; ISSUE directly follows the 4th word; opb=0.
REQ-044 Unit=000 with no unit_done and TIMEOUT=255 -> res_valid and res_error=1 exactly 255 cycles after ISSUE.
REQ-045 cmd_size=11 -> res_error=1 one cycle after accept, with no unit_start.
REQ-046 Reset asserted after 2 of 4 LOAD_A words -> IDLE and busy=0; the next command loads cleanly from a zeroed opa.

Source files
------------

// File: rtl/op_sequencer.sv
// Operation sequencer: accepts a command, gathers up to two multi-word
// operands, starts one of four execution units, waits for its completion
// (with abort after TIMEOUT cycles) and reports a single result strobe.
// Fetch and store commands act on a small local 4x64 register file.
module op_sequencer #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_unit,
  input  logic [2:0]  cmd_op,
  input  logic [1:0]  cmd_size,
  input  logic        word_valid,
  output logic        word_ready,
  input  logic [15:0] word_data,
  output logic [3:0]  unit_start,
  output logic [2:0]  unit_op,
  output logic [63:0] opa,
  output logic [63:0] opb,
  input  logic [3:0]  unit_done,
  input  logic [63:0] unit_result,
  output logic        res_valid,
  output logic [63:0] res_data,
  output logic        res_sign,
  output logic        res_error,
  output logic        busy
);

  // Wide enough to hold TIMEOUT itself without wrapping.
  localparam int CW = $clog2(TIMEOUT + 2);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_A, S_LOAD_B, S_ISSUE, S_WAIT, S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [2:0]    unit_q, unit_d;
  logic [2:0]    op_q, op_d;
  logic [1:0]    last_q, last_d;      // index of the final word (N-1)
  logic [1:0]    wcnt_q, wcnt_d;      // index of the next word to land
  logic [CW-1:0] cnt_q, cnt_d;        // cycles elapsed since ISSUE
  logic [63:0]   opa_q, opa_d;
  logic [63:0]   opb_q, opb_d;
  logic [63:0]   res_data_q, res_data_d;
  logic [3:0]    start_q, start_d;
  logic          res_valid_q, res_valid_d;
  logic          res_error_q, res_error_d;
  logic [63:0]   regs_q [4];
  logic [63:0]   regs_d [4];

  logic [63:0]   opa_ins, opb_ins;
  logic          unary;
  logic          last_word;
  logic [3:0]    sel_onehot;

  // Store, int_calc op 100 and int_log op 110 need only operand A.
  assign unary      = (unit_q == 3'b101) ||
                      (unit_q == 3'b001 && op_q == 3'b100) ||
                      (unit_q == 3'b011 && op_q == 3'b110);
  assign last_word  = (wcnt_q == last_q);
  assign sel_onehot = 4'b0001 << unit_q[1:0];

  // Operand values with the current word merged into its 16-bit lane.
  always_comb begin
    opa_ins = opa_q;
    opb_ins = opb_q;
    opa_ins[{wcnt_q, 4'b0000} +: 16] = word_data;
    opb_ins[{wcnt_q, 4'b0000} +: 16] = word_data;
  end

  // Next-state and next-output computation for the whole sequencer.
  always_comb begin
    state_d     = state_q;
    unit_d      = unit_q;
    op_d        = op_q;
    last_d      = last_q;
    wcnt_d      = wcnt_q;
    cnt_d       = cnt_q;
    opa_d       = opa_q;
    opb_d       = opb_q;
    res_data_d  = res_data_q;
    start_d     = 4'b0000;
    res_valid_d = 1'b0;
    res_error_d = 1'b0;
    regs_d      = regs_q;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          opa_d  = '0;
          opb_d  = '0;
          wcnt_d = '0;
          unit_d = cmd_unit;
          op_d   = cmd_op;
          case (cmd_size)
            2'b00:   last_d = 2'd0;
            2'b01:   last_d = 2'd1;
            default: last_d = 2'd3;
          endcase
          if (cmd_unit[2:1] == 2'b11 || cmd_size == 2'b11) begin
            state_d     = S_DONE;
            res_valid_d = 1'b1;
            res_error_d = 1'b1;
            res_data_d  = '0;
          end else if (cmd_unit == 3'b100) begin
            state_d     = S_DONE;
            res_valid_d = 1'b1;
            res_data_d  = regs_q[cmd_op[1:0]];
          end else begin
            state_d = S_LOAD_A;
          end
        end
      end
      S_LOAD_A: begin
        if (word_valid) begin
          opa_d  = opa_ins;
          wcnt_d = wcnt_q + 2'd1;
          if (last_word) begin
            wcnt_d = '0;
            if (unit_q == 3'b101) begin
              regs_d[op_q[1:0]] = opa_ins;
              state_d     = S_DONE;
              res_valid_d = 1'b1;
              res_data_d  = opa_ins;
            end else if (unary) begin
              state_d = S_ISSUE;
              start_d = sel_onehot;
              cnt_d   = '0;
            end else begin
              state_d = S_LOAD_B;
            end
          end
        end
      end
      S_LOAD_B: begin
        if (word_valid) begin
          opb_d  = opb_ins;
          wcnt_d = wcnt_q + 2'd1;
          if (last_word) begin
            wcnt_d  = '0;
            state_d = S_ISSUE;
            start_d = sel_onehot;
            cnt_d   = '0;
          end
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
        cnt_d   = cnt_q + CW'(1);
      end
      S_WAIT: begin
        if (unit_done[unit_q[1:0]]) begin
          state_d     = S_DONE;
          res_valid_d = 1'b1;
          res_data_d  = unit_result;
        end else if (int'(cnt_q) + 1 >= TIMEOUT) begin
          state_d     = S_DONE;
          res_valid_d = 1'b1;
          res_error_d = 1'b1;
          res_data_d  = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Sequencer state and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      unit_q      <= '0;
      op_q        <= '0;
      last_q      <= '0;
      wcnt_q      <= '0;
      cnt_q       <= '0;
      opa_q       <= '0;
      opb_q       <= '0;
      res_data_q  <= '0;
      start_q     <= '0;
      res_valid_q <= 1'b0;
      res_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      unit_q      <= unit_d;
      op_q        <= op_d;
      last_q      <= last_d;
      wcnt_q      <= wcnt_d;
      cnt_q       <= cnt_d;
      opa_q       <= opa_d;
      opb_q       <= opb_d;
      res_data_q  <= res_data_d;
      start_q     <= start_d;
      res_valid_q <= res_valid_d;
      res_error_q <= res_error_d;
    end
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_regs
    // One register-file entry, cleared by reset, written only by store.
    always_ff @(posedge clk) begin
      if (reset) regs_q[gi] <= '0;
      else       regs_q[gi] <= regs_d[gi];
    end
  end

  assign cmd_ready  = (state_q == S_IDLE);
  assign word_ready = (state_q == S_LOAD_A) || (state_q == S_LOAD_B);
  assign busy       = (state_q != S_IDLE);
  assign unit_start = start_q;
  assign unit_op    = op_q;
  assign opa        = opa_q;
  assign opb        = opb_q;
  assign res_valid  = res_valid_q;
  assign res_error  = res_error_q;
  assign res_data   = res_data_q;
  assign res_sign   = res_data_q[63];

endmodule

// File: tb/tb_op_sequencer.sv
// Bench for op_sequencer: a transaction-level driver predicts, cycle by
// cycle, what every output must show; a negedge process compares.
module tb_op_sequencer;
  localparam int TIMEOUT = 255;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready;
  logic [2:0]  cmd_unit, cmd_op;
  logic [1:0]  cmd_size;
  logic        word_valid, word_ready;
  logic [15:0] word_data;
  logic [3:0]  unit_start, unit_done;
  logic [2:0]  unit_op;
  logic [63:0] opa, opb, unit_result, res_data;
  logic        res_valid, res_sign, res_error, busy;

  always #5 clk = ~clk;

  op_sequencer #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_unit(cmd_unit), .cmd_op(cmd_op), .cmd_size(cmd_size),
    .word_valid(word_valid), .word_ready(word_ready), .word_data(word_data),
    .unit_start(unit_start), .unit_op(unit_op), .opa(opa), .opb(opb),
    .unit_done(unit_done), .unit_result(unit_result),
    .res_valid(res_valid), .res_data(res_data), .res_sign(res_sign),
    .res_error(res_error), .busy(busy)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  // expected values for the current cycle
  logic        e_busy, e_cmd_ready, e_word_ready, e_res_valid, e_res_error;
  logic [3:0]  e_start;
  logic [63:0] e_res, e_opa, e_opb;
  logic [2:0]  e_op;
  bit          e_chk_ops;
  logic [63:0] mregs [4];

  // observations recorded from the DUT by the compare process
  int          start_cyc = 0, rv_cyc = 0, start_cnt = 0, acc_cyc = 0;
  logic [63:0] last_res, last_opa, last_opb;
  logic        last_err;
  logic [3:0]  last_start;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // per-cycle comparison against the driver's prediction
  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", 64'(busy), 64'(e_busy));
      chk("cmd_ready", 64'(cmd_ready), 64'(e_cmd_ready));
      chk("word_ready", 64'(word_ready), 64'(e_word_ready));
      chk("unit_start", 64'(unit_start), 64'(e_start));
      chk("res_valid", 64'(res_valid), 64'(e_res_valid));
      chk("res_error", 64'(res_error), 64'(e_res_error));
      chk("res_data", res_data, e_res);
      chk("res_sign", 64'(res_sign), 64'(e_res[63]));
      if (e_chk_ops) begin
        chk("opa", opa, e_opa);
        chk("opb", opb, e_opb);
        chk("unit_op", 64'(unit_op), 64'(e_op));
      end
      if (unit_start != 4'b0000) begin
        start_cyc  = cyc;
        start_cnt  = start_cnt + 1;
        last_start = unit_start;
      end
      if (res_valid) begin
        rv_cyc   = cyc;
        last_res = res_data;
        last_err = res_error;
        last_opa = opa;
        last_opb = opb;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    e_busy = 0; e_cmd_ready = 1; e_word_ready = 0;
    e_res_valid = 0; e_res_error = 0; e_start = 0; e_chk_ops = 0;
  endtask

  task automatic set_busy(input bit wr);
    e_busy = 1; e_cmd_ready = 0; e_word_ready = wr;
    e_res_valid = 0; e_res_error = 0; e_start = 0; e_chk_ops = 1;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 4; i++) mregs[i] = '0;
    e_res = '0;
  endtask

  // deliver n words from w, with random stalls, into operand A or B
  task automatic load_words(input logic [63:0] w, input int n, input bit b);
    for (int k = 0; k < n; k++) begin
      while ($urandom_range(0, 3) == 0) begin
        word_valid = 0; word_data = 16'($urandom); unit_done = 4'($urandom);
        tick();
      end
      word_valid = 1; word_data = w[16*k +: 16]; unit_done = 4'($urandom);
      tick();
      if (b) e_opb[16*k +: 16] = w[16*k +: 16];
      else   e_opa[16*k +: 16] = w[16*k +: 16];
    end
    word_valid = 0;
  endtask

  // one full command; dly = cycles after start when the unit reports done
  task automatic run_cmd(input logic [2:0] unit, input logic [2:0] op,
                         input logic [1:0] size, input logic [63:0] wa,
                         input logic [63:0] wb, input int dly, input int gap,
                         input bit fix, input logic [63:0] fres);
    int n;
    logic illegal, un;
    logic [3:0] selm;
    logic [63:0] r;
    for (int g = 0; g < gap; g++) begin
      cmd_valid = 0; cmd_unit = 3'($urandom); cmd_op = 3'($urandom);
      cmd_size = 2'($urandom); word_valid = 1'($urandom);
      word_data = 16'($urandom); unit_done = 4'($urandom);
      tick();
    end
    cmd_valid = 1; cmd_unit = unit; cmd_op = op; cmd_size = size;
    word_valid = 0; unit_done = 0;
    tick();
    acc_cyc = cyc;
    cmd_valid = 0; cmd_unit = 3'($urandom); cmd_op = 3'($urandom); cmd_size = 2'($urandom);
    illegal = (unit[2:1] == 2'b11) || (size == 2'b11);
    e_op = op; e_opa = '0; e_opb = '0;
    if (illegal || unit == 3'b100) begin
      set_busy(0);
      e_res_valid = 1; e_res_error = illegal;
      e_res = illegal ? 64'd0 : mregs[op[1:0]];
      tick();
      set_idle();
      return;
    end
    n = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    set_busy(1);
    load_words(wa, n, 0);
    if (unit == 3'b101) begin
      set_busy(0);
      mregs[op[1:0]] = e_opa;
      e_res_valid = 1; e_res = e_opa;
      tick();
      set_idle();
      return;
    end
    un = (unit == 3'b001 && op == 3'b100) || (unit == 3'b011 && op == 3'b110);
    if (!un) begin
      set_busy(1);
      load_words(wb, n, 1);
    end
    selm = 4'b0001 << unit[1:0];
    set_busy(0);
    e_start = selm;
    for (int j = 0; j <= TIMEOUT; j++) begin
      unit_done = (4'($urandom) & ~selm) | ((j == dly && j >= 1) ? selm : 4'b0000);
      r = fix ? fres : {$urandom, $urandom};
      unit_result = r;
      tick();
      set_busy(0);
      if (j >= 1 && j == dly) begin
        e_res_valid = 1; e_res = r;
        break;
      end
      if (j >= 1 && j + 1 >= TIMEOUT) begin
        e_res_valid = 1; e_res_error = 1; e_res = '0;
        break;
      end
    end
    unit_done = 0;
    tick();
    set_idle();
  endtask

  int sc;
  logic [2:0] ru, ro;

  initial begin
    reset = 1; cmd_valid = 0; cmd_unit = 0; cmd_op = 0; cmd_size = 0;
    word_valid = 0; word_data = 0; unit_done = 0; unit_result = 0;
    last_res = 0; last_opa = 0; last_opb = 0; last_err = 0; last_start = 0;
    e_opa = 0; e_opb = 0; e_op = 0;
    tick(); tick();
    set_idle(); clear_model();
    chk_en = 1;
    chk("rst_unit_op", 64'(unit_op), 64'd0);
    chk("rst_opa", opa, 64'd0);
    chk("rst_opb", opb, 64'd0);
    reset = 0;

    // store two words into reg 2, then fetch it back
    run_cmd(3'b101, 3'b010, 2'b01, 64'h0000_0000_ABCD_1234, 64'd0, 1, 1, 0, 0);
    chk("store_res", last_res, 64'h0000_0000_ABCD_1234);
    run_cmd(3'b100, 3'b010, 2'b00, 64'd0, 64'd0, 1, 2, 0, 0);
    chk("fetch_res", last_res, 64'h0000_0000_ABCD_1234);
    chk("fetch_latency", 64'(rv_cyc - acc_cyc), 64'd0);

    // int_calc add with done three cycles after start
    run_cmd(3'b001, 3'b000, 2'b00, 64'h5, 64'h3, 3, 1, 1, 64'd8);
    chk("add_opa", last_opa, 64'd5);
    chk("add_opb", last_opb, 64'd3);
    chk("add_start", 64'(last_start), 64'h2);
    chk("add_res", last_res, 64'd8);
    chk("add_err", 64'(last_err), 64'd0);
    chk("add_done_latency", 64'(rv_cyc - start_cyc), 64'd4);

    // unary int_log with four words: no operand B
    run_cmd(3'b011, 3'b110, 2'b10, 64'h1111_2222_3333_4444, 64'hFFFF, 2, 0, 0, 0);
    chk("unary_opb", last_opb, 64'd0);
    chk("unary_opa", last_opa, 64'h1111_2222_3333_4444);

    // fpu never answers: timeout
    run_cmd(3'b000, 3'b001, 2'b00, 64'h7, 64'h9, 100000, 1, 0, 0);
    chk("timeout_latency", 64'(rv_cyc - start_cyc), 64'd255);
    chk("timeout_err", 64'(last_err), 64'd1);

    // done in the final cycle before timeout wins
    run_cmd(3'b010, 3'b011, 2'b00, 64'h1, 64'h2, TIMEOUT - 1, 0, 1, 64'hDEAD_BEEF_0000_0001);
    chk("late_done_err", 64'(last_err), 64'd0);
    chk("late_done_res", last_res, 64'hDEAD_BEEF_0000_0001);

    // illegal size
    sc = start_cnt;
    run_cmd(3'b001, 3'b000, 2'b11, 64'd0, 64'd0, 1, 1, 0, 0);
    chk("illegal_err", 64'(last_err), 64'd1);
    chk("illegal_latency", 64'(rv_cyc - acc_cyc), 64'd0);
    chk("illegal_no_start", 64'(start_cnt - sc), 64'd0);

    // reset after two of four operand-A words
    cmd_valid = 1; cmd_unit = 3'b001; cmd_op = 3'b000; cmd_size = 2'b10;
    tick();
    cmd_valid = 0;
    e_op = 3'b000; e_opa = '0; e_opb = '0;
    set_busy(1);
    for (int k = 0; k < 2; k++) begin
      word_valid = 1; word_data = 16'hA5A0 + 16'(k);
      tick();
      e_opa[16*k +: 16] = 16'hA5A0 + 16'(k);
    end
    reset = 1; word_valid = 1; cmd_valid = 1; unit_done = 4'hF;
    tick();
    reset = 0; word_valid = 0; cmd_valid = 0; unit_done = 0;
    set_idle(); clear_model();
    chk("midload_busy", 64'(busy), 64'd0);
    chk("midload_opa", opa, 64'd0);
    run_cmd(3'b001, 3'b000, 2'b10, 64'h0004_0003_0002_0001, 64'h8, 2, 1, 0, 0);
    chk("reload_opa", last_opa, 64'h0004_0003_0002_0001);
    run_cmd(3'b100, 3'b010, 2'b00, 64'd0, 64'd0, 1, 0, 0, 0);
    chk("fetch_after_reset", last_res, 64'd0);

    // randomized traffic
    for (int t = 0; t < 60; t++) begin
      ru = 3'($urandom);
      ro = 3'($urandom);
      if ($urandom_range(0, 2) == 0) ro = (ru == 3'b011) ? 3'b110 : 3'b100;
      run_cmd(ru, ro, ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2)),
              {$urandom, $urandom}, {$urandom, $urandom},
              ($urandom_range(0, 29) == 0) ? 100000 : $urandom_range(1, 8),
              $urandom_range(0, 3), 0, 0);
    end

    tick();
    chk_en = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
